// File: rtl/counter_arbiter_if.sv
// Requester/counter-side signal bundle for counter_arbiter.
// master = requesters plus counter RCO; slave = the arbiter itself.
interface counter_arbiter_if #(
    parameter int LEN_W = 4
);
    logic             req0;
    logic [1:0]       mode0;
    logic [3:0]       d0;
    logic [LEN_W-1:0] len0;
    logic             req1;
    logic [1:0]       mode1;
    logic [3:0]       d1;
    logic [LEN_W-1:0] len1;
    logic             ctr_rco;
    logic             ENABLE;
    logic [1:0]       MODO;
    logic [3:0]       D;
    logic             gnt0;
    logic             gnt1;
    logic             done0;
    logic             done1;
    logic             rco_hit;
    logic             busy;

    modport master (
        output req0, mode0, d0, len0, req1, mode1, d1, len1, ctr_rco,
        input  ENABLE, MODO, D, gnt0, gnt1, done0, done1, rco_hit, busy
    );

    modport slave (
        input  req0, mode0, d0, len0, req1, mode1, d1, len1, ctr_rco,
        output ENABLE, MODO, D, gnt0, gnt1, done0, done1, rco_hit, busy
    );
endinterface

// File: rtl/counter_arbiter.sv
// Two-requester arbiter sequencing LOAD/RUN/DONE jobs on a shared 4-bit counter.
// Outputs are decoded from registered state and captured job fields only.
module counter_arbiter #(
    parameter int LEN_W       = 4,
    parameter bit STOP_ON_RCO = 1'b1
) (
    input  logic              clk,
    input  logic              RESET,
    counter_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic             r_sel;
    logic             r_last;
    logic [1:0]       r_mode_q;
    logic [3:0]       r_d_q;
    logic [LEN_W-1:0] r_cnt;
    logic             r_rco_q;

    logic             w_any_req;
    logic             w_win;
    logic             w_enable;
    logic [1:0]       w_modo;
    logic             w_job;
    logic             w_done;
    logic             w_rco_hit;

    assign w_any_req = bus.req0 | bus.req1;

    // On a tie the requester not granted last wins.
    always_comb begin
        w_win = 1'b0;
        if (bus.req0 && bus.req1) begin
            w_win = ~r_last;
        end else if (bus.req1) begin
            w_win = 1'b1;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_enable   = 1'b0;
        w_modo     = 2'b00;
        w_job      = 1'b0;
        w_done     = 1'b0;
        w_rco_hit  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                w_enable = 1'b1;
                w_modo   = 2'b11;
                w_job    = 1'b1;
                if ((r_mode_q != 2'b11) && (r_cnt != '0)) begin
                    w_state_nx = S_RUN;
                end else begin
                    w_state_nx = S_DONE;
                end
            end
            S_RUN: begin
                w_enable = 1'b1;
                w_modo   = r_mode_q;
                w_job    = 1'b1;
                if ((r_cnt == LEN_W'(1)) || (STOP_ON_RCO && bus.ctr_rco)) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                w_job      = 1'b1;
                w_done     = 1'b1;
                w_rco_hit  = r_rco_q;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_sel    <= 1'b0;
            r_last   <= 1'b1;
            r_mode_q <= 2'b00;
            r_d_q    <= '0;
            r_cnt    <= '0;
            r_rco_q  <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && w_any_req) begin
                r_sel    <= w_win;
                r_last   <= w_win;
                r_mode_q <= w_win ? bus.mode1 : bus.mode0;
                r_d_q    <= w_win ? bus.d1 : bus.d0;
                r_cnt    <= w_win ? bus.len1 : bus.len0;
                r_rco_q  <= 1'b0;
            end
            // RUN is only entered with r_cnt != 0, so this never wraps.
            if (r_state == S_RUN) begin
                r_cnt <= r_cnt - LEN_W'(1);
                if (bus.ctr_rco) begin
                    r_rco_q <= 1'b1;
                end
            end
        end
    end

    assign bus.ENABLE  = w_enable;
    assign bus.MODO    = w_modo;
    assign bus.D       = r_d_q;
    assign bus.gnt0    = w_job & ~r_sel;
    assign bus.gnt1    = w_job & r_sel;
    assign bus.done0   = w_done & ~r_sel;
    assign bus.done1   = w_done & r_sel;
    assign bus.rco_hit = w_rco_hit;
    assign bus.busy    = (r_state != S_IDLE);
endmodule

// File: tb/tb_counter_arbiter.sv
// Bench for counter_arbiter: vector table, directed RCO/reset sequences and
// random traffic against a job-level model; DUT A stops on RCO, DUT B does not.
module tb_counter_arbiter;
    localparam int LEN_W = 4;
    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_RUN  = 2;
    localparam int P_DONE = 3;

    logic clk = 1'b0;
    logic RESET = 1'b1;
    always #5 clk = ~clk;

    logic             s_req0 = 1'b0, s_req1 = 1'b0, s_rco = 1'b0;
    logic [1:0]       s_mode0 = '0, s_mode1 = '0;
    logic [3:0]       s_d0 = '0, s_d1 = '0;
    logic [LEN_W-1:0] s_len0 = '0, s_len1 = '0;

    counter_arbiter_if #(.LEN_W(LEN_W)) ia ();
    counter_arbiter_if #(.LEN_W(LEN_W)) ib ();

    assign ia.req0 = s_req0;  assign ib.req0 = s_req0;
    assign ia.mode0 = s_mode0; assign ib.mode0 = s_mode0;
    assign ia.d0 = s_d0;      assign ib.d0 = s_d0;
    assign ia.len0 = s_len0;  assign ib.len0 = s_len0;
    assign ia.req1 = s_req1;  assign ib.req1 = s_req1;
    assign ia.mode1 = s_mode1; assign ib.mode1 = s_mode1;
    assign ia.d1 = s_d1;      assign ib.d1 = s_d1;
    assign ia.len1 = s_len1;  assign ib.len1 = s_len1;
    assign ia.ctr_rco = s_rco; assign ib.ctr_rco = s_rco;

    counter_arbiter #(.LEN_W(LEN_W), .STOP_ON_RCO(1'b1)) u_stop (
        .clk(clk), .RESET(RESET), .bus(ia.slave));
    counter_arbiter #(.LEN_W(LEN_W), .STOP_ON_RCO(1'b0)) u_free (
        .clk(clk), .RESET(RESET), .bus(ib.slave));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Job-level reference: tracks which part of the job we are in and how
    // many RUN cycles have elapsed against the requested length.
    int  m_ph[2], m_sel[2], m_last[2], m_mode[2], m_d[2], m_len[2], m_runs[2];
    bit  m_rco[2];
    bit  m_valid = 1'b0;

    task automatic model_step();
        for (int u = 0; u < 2; u++) begin
            if (RESET) begin
                m_ph[u] = P_IDLE; m_last[u] = 1; m_sel[u] = 0;
                m_mode[u] = 0; m_d[u] = 0; m_rco[u] = 1'b0;
            end else begin
                case (m_ph[u])
                    P_IDLE: if (s_req0 || s_req1) begin
                        int w;
                        w = (s_req0 && s_req1) ? 1 - m_last[u] : (s_req1 ? 1 : 0);
                        m_last[u] = w; m_sel[u] = w;
                        m_mode[u] = int'(w == 1 ? s_mode1 : s_mode0);
                        m_d[u]    = int'(w == 1 ? s_d1 : s_d0);
                        m_len[u]  = int'(w == 1 ? s_len1 : s_len0);
                        m_runs[u] = 0; m_rco[u] = 1'b0;
                        m_ph[u]   = P_LOAD;
                    end
                    P_LOAD: m_ph[u] = (m_mode[u] == 3 || m_len[u] == 0) ? P_DONE : P_RUN;
                    P_RUN: begin
                        m_runs[u]++;
                        if (s_rco) m_rco[u] = 1'b1;
                        if (m_runs[u] >= m_len[u] || (u == 0 && s_rco)) m_ph[u] = P_DONE;
                    end
                    default: m_ph[u] = P_IDLE;
                endcase
            end
        end
        if (RESET) m_valid = 1'b1;
    endtask

    task automatic check_dut(input int u, input string p, input logic en, input logic [1:0] modo,
                             input logic [3:0] dd, input logic g0, input logic g1,
                             input logic dn0, input logic dn1, input logic hit, input logic bsy);
        int ph;
        if (!m_valid) return;
        ph = m_ph[u];
        chk({p, ".ENABLE"}, 8'(en), 8'(ph == P_LOAD || ph == P_RUN));
        chk({p, ".MODO"}, 8'(modo), 8'(ph == P_LOAD ? 3 : (ph == P_RUN ? m_mode[u] : 0)));
        chk({p, ".D"}, 8'(dd), 8'(m_d[u]));
        chk({p, ".gnt0"}, 8'(g0), 8'(ph != P_IDLE && m_sel[u] == 0));
        chk({p, ".gnt1"}, 8'(g1), 8'(ph != P_IDLE && m_sel[u] == 1));
        chk({p, ".done0"}, 8'(dn0), 8'(ph == P_DONE && m_sel[u] == 0));
        chk({p, ".done1"}, 8'(dn1), 8'(ph == P_DONE && m_sel[u] == 1));
        chk({p, ".rco_hit"}, 8'(hit), 8'(ph == P_DONE && m_rco[u]));
        chk({p, ".busy"}, 8'(bsy), 8'(ph != P_IDLE));
        chk({p, ".gnt_excl"}, 8'(g0 & g1), 8'(0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_dut(0, "A", ia.ENABLE, ia.MODO, ia.D, ia.gnt0, ia.gnt1, ia.done0, ia.done1, ia.rco_hit, ia.busy);
        check_dut(1, "B", ib.ENABLE, ib.MODO, ib.D, ib.gnt0, ib.gnt1, ib.done0, ib.done1, ib.rco_hit, ib.busy);
    endtask

    typedef struct {
        int rst, r0, m0, d0, l0, r1, m1, d1, l1, rco;
        int en, modo, dd, g0, g1, dn0, dn1, hit, busy;
    } vec_t;

    function automatic vec_t V(input int rst, r0, m0, d0, l0, r1, m1, d1, l1, rco,
                               input int en, modo, dd, g0, g1, dn0, dn1, hit, busy);
        vec_t v;
        v = '{rst, r0, m0, d0, l0, r1, m1, d1, l1, rco, en, modo, dd, g0, g1, dn0, dn1, hit, busy};
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        int runs_a, runs_b, hit_a, hit_b, seen_b;

        tbl.push_back(V(1, 0,0,0,0, 0,0,0,0, 0,  0,0,0, 0,0,0,0,0,0));
        tbl.push_back(V(1, 0,0,0,0, 0,0,0,0, 0,  0,0,0, 0,0,0,0,0,0));
        tbl.push_back(V(0, 0,0,0,0, 0,0,0,0, 0,  0,0,0, 0,0,0,0,0,0));
        // len=3 job on requester 0
        tbl.push_back(V(0, 1,2,5,3, 0,0,0,0, 0,  1,3,5, 1,0,0,0,0,1));
        tbl.push_back(V(0, 0,2,5,3, 0,0,0,0, 0,  1,2,5, 1,0,0,0,0,1));
        tbl.push_back(V(0, 0,2,5,3, 0,0,0,0, 0,  1,2,5, 1,0,0,0,0,1));
        tbl.push_back(V(0, 0,2,5,3, 0,0,0,0, 0,  1,2,5, 1,0,0,0,0,1));
        tbl.push_back(V(0, 0,0,0,0, 0,0,0,0, 0,  0,0,5, 1,0,1,0,0,1));
        tbl.push_back(V(0, 0,0,0,0, 0,0,0,0, 0,  0,0,5, 0,0,0,0,0,0));
        // load-only: mode=11, with RCO high outside RUN
        tbl.push_back(V(0, 0,0,0,0, 1,3,9,5, 1,  1,3,9, 0,1,0,0,0,1));
        tbl.push_back(V(0, 0,0,0,0, 0,3,9,5, 1,  0,0,9, 0,1,0,1,0,1));
        tbl.push_back(V(0, 0,0,0,0, 0,0,0,0, 0,  0,0,9, 0,0,0,0,0,0));
        // load-only: len=0
        tbl.push_back(V(0, 0,0,0,0, 1,1,12,0, 0, 1,3,12, 0,1,0,0,0,1));
        tbl.push_back(V(0, 0,0,0,0, 0,1,12,0, 0, 0,0,12, 0,1,0,1,0,1));
        tbl.push_back(V(0, 0,0,0,0, 0,0,0,0, 0,  0,0,12, 0,0,0,0,0,0));
        // continuous contention, len=1 each: 0, 1, 0
        tbl.push_back(V(0, 1,2,3,1, 1,2,7,1, 0,  1,3,3, 1,0,0,0,0,1));
        tbl.push_back(V(0, 1,2,3,1, 1,2,7,1, 0,  1,2,3, 1,0,0,0,0,1));
        tbl.push_back(V(0, 1,2,3,1, 1,2,7,1, 0,  0,0,3, 1,0,1,0,0,1));
        tbl.push_back(V(0, 1,2,3,1, 1,2,7,1, 0,  0,0,3, 0,0,0,0,0,0));
        tbl.push_back(V(0, 1,2,3,1, 1,2,7,1, 0,  1,3,7, 0,1,0,0,0,1));
        tbl.push_back(V(0, 1,2,3,1, 1,2,7,1, 0,  1,2,7, 0,1,0,0,0,1));
        tbl.push_back(V(0, 1,2,3,1, 1,2,7,1, 0,  0,0,7, 0,1,0,1,0,1));
        tbl.push_back(V(0, 1,2,3,1, 1,2,7,1, 0,  0,0,7, 0,0,0,0,0,0));
        tbl.push_back(V(0, 1,2,3,1, 1,2,7,1, 0,  1,3,3, 1,0,0,0,0,1));
        tbl.push_back(V(0, 0,0,0,0, 0,0,0,0, 0,  1,2,3, 1,0,0,0,0,1));
        tbl.push_back(V(0, 0,0,0,0, 0,0,0,0, 0,  0,0,3, 1,0,1,0,0,1));
        tbl.push_back(V(0, 0,0,0,0, 0,0,0,0, 0,  0,0,3, 0,0,0,0,0,0));

        @(negedge clk);
        foreach (tbl[i]) begin
            RESET = 1'(tbl[i].rst);
            s_req0 = 1'(tbl[i].r0); s_mode0 = 2'(tbl[i].m0); s_d0 = 4'(tbl[i].d0); s_len0 = LEN_W'(tbl[i].l0);
            s_req1 = 1'(tbl[i].r1); s_mode1 = 2'(tbl[i].m1); s_d1 = 4'(tbl[i].d1); s_len1 = LEN_W'(tbl[i].l1);
            s_rco = 1'(tbl[i].rco);
            tick();
            chk($sformatf("vec%0d.ENABLE", i), 8'(ia.ENABLE), 8'(tbl[i].en));
            chk($sformatf("vec%0d.MODO", i), 8'(ia.MODO), 8'(tbl[i].modo));
            chk($sformatf("vec%0d.D", i), 8'(ia.D), 8'(tbl[i].dd));
            chk($sformatf("vec%0d.gnt0", i), 8'(ia.gnt0), 8'(tbl[i].g0));
            chk($sformatf("vec%0d.gnt1", i), 8'(ia.gnt1), 8'(tbl[i].g1));
            chk($sformatf("vec%0d.done0", i), 8'(ia.done0), 8'(tbl[i].dn0));
            chk($sformatf("vec%0d.done1", i), 8'(ia.done1), 8'(tbl[i].dn1));
            chk($sformatf("vec%0d.rco_hit", i), 8'(ia.rco_hit), 8'(tbl[i].hit));
            chk($sformatf("vec%0d.busy", i), 8'(ia.busy), 8'(tbl[i].busy));
        end

        // RCO on the 2nd RUN cycle of a len=8, +3 job
        RESET = 1'b1; s_req0 = 1'b0; s_req1 = 1'b0; s_rco = 1'b0;
        tick();
        RESET = 1'b0; s_req0 = 1'b1; s_mode0 = 2'b00; s_d0 = 4'd2; s_len0 = LEN_W'(8);
        tick();
        s_req0 = 1'b0;
        runs_a = 0; runs_b = 0; hit_a = 0; hit_b = 0; seen_b = 0;
        for (int k = 1; k <= 30 && seen_b == 0; k++) begin
            s_rco = (k == 3);
            tick();
            if (ia.ENABLE && ia.MODO != 2'b11) runs_a++;
            if (ib.ENABLE && ib.MODO != 2'b11) runs_b++;
            if (ia.done0) hit_a = int'(ia.rco_hit);
            if (ib.done0) begin hit_b = int'(ib.rco_hit); seen_b = 1; end
        end
        s_rco = 1'b0;
        chk("rco.free_done_seen", 8'(seen_b), 8'(1));
        chk("rco.stop_runs", 8'(runs_a), 8'(2));
        chk("rco.stop_hit", 8'(hit_a), 8'(1));
        chk("rco.free_runs", 8'(runs_b), 8'(8));
        chk("rco.free_hit", 8'(hit_b), 8'(1));
        tick();

        // RESET during the 2nd RUN cycle of a len=5 job
        s_req0 = 1'b1; s_mode0 = 2'b10; s_d0 = 4'd4; s_len0 = LEN_W'(5);
        tick();
        s_req0 = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
        tick();
        chk("rst.ENABLE", 8'(ia.ENABLE), 8'(0));
        chk("rst.gnt0", 8'(ia.gnt0), 8'(0));
        chk("rst.done0", 8'(ia.done0), 8'(0));
        chk("rst.busy", 8'(ia.busy), 8'(0));
        chk("rst.D", 8'(ia.D), 8'(0));
        RESET = 1'b0;
        tick();
        chk("rst.no_done0", 8'(ia.done0), 8'(0));
        s_req0 = 1'b1; s_req1 = 1'b1; s_len0 = LEN_W'(2); s_len1 = LEN_W'(2);
        tick();
        chk("rst.tie_gnt0", 8'(ia.gnt0), 8'(1));
        chk("rst.tie_gnt1", 8'(ia.gnt1), 8'(0));
        s_req0 = 1'b0; s_req1 = 1'b0;
        repeat (5) tick();

        // random traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            RESET   = ($urandom_range(0, 299) == 0);
            s_req0  = ($urandom_range(0, 2) != 0);
            s_req1  = ($urandom_range(0, 2) != 0);
            s_mode0 = 2'($urandom_range(0, 3));
            s_mode1 = 2'($urandom_range(0, 3));
            s_d0    = 4'($urandom_range(0, 15));
            s_d1    = 4'($urandom_range(0, 15));
            s_len0  = LEN_W'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 15 : 5));
            s_len1  = LEN_W'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 15 : 5));
            s_rco   = ($urandom_range(0, 5) == 0);
            tick();
        end
        RESET = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
